// File: rtl/div_sequencer_pkg.sv
// Shared types and opcode helpers for the multi-cycle divide/remainder sequencer.
package div_sequencer_pkg;

  localparam logic [4:0] ALU_DIV  = 5'd12;
  localparam logic [4:0] ALU_DIVU = 5'd13;
  localparam logic [4:0] ALU_REM  = 5'd14;
  localparam logic [4:0] ALU_REMU = 5'd15;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_CALC = 2'd1,
    DS_FIX  = 2'd2,
    DS_DONE = 2'd3
  } ds_state_e;

  function automatic logic is_div_op(input logic [4:0] sel);
    logic r;
    case (sel)
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: r = 1'b1;
      default:                              r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_signed_op(input logic [4:0] sel);
    logic r;
    case (sel)
      ALU_DIV, ALU_REM: r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_rem_op(input logic [4:0] sel);
    logic r;
    case (sel)
      ALU_REM, ALU_REMU: r = 1'b1;
      default:           r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/div_sequencer_iter_step.sv
// One restoring-division step: shift {rem,quo} left, subtract divisor if it fits.
module div_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   partial_s;
  logic [WIDTH-1:0] trial_s;
  logic             ge_s;

  // Partial remainder needs one extra bit; the difference always fits in WIDTH when taken.
  always_comb begin
    partial_s = {rem_i, quo_i[WIDTH-1]};
    trial_s   = partial_s[WIDTH-1:0] - divisor_i;
    ge_s      = (partial_s >= {1'b0, divisor_i});
    if (ge_s) begin
      rem_o = trial_s;
    end else begin
      rem_o = partial_s[WIDTH-1:0];
    end
    quo_o = {quo_i[WIDTH-2:0], ge_s};
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: magnitude restoring division plus RISC-V sign fix-up.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [4:0]       alu_sel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  ds_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, divisor_q, divisor_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d, is_rem_q, is_rem_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic             accept_s, signed_s, rem_sel_s, div_zero_s, overflow_s;
  logic             a_neg_s, b_neg_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s, step_rem_s, step_quo_s, q_fix_s, r_fix_s;

  div_iter_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (step_rem_s),
    .quo_o     (step_quo_s)
  );

  // Request decode, corner-case detection and operand magnitudes.
  always_comb begin
    accept_s   = (state_q == DS_IDLE) && start && is_div_op(alu_sel) && !flush;
    signed_s   = is_signed_op(alu_sel);
    rem_sel_s  = is_rem_op(alu_sel);
    div_zero_s = (op_b == ZERO);
    overflow_s = signed_s && (op_a == MIN_NEG) && (op_b == ALL_ONES);
    a_neg_s    = signed_s && op_a[WIDTH-1];
    b_neg_s    = signed_s && op_b[WIDTH-1];
    a_mag_s    = a_neg_s ? (ZERO - op_a) : op_a;
    b_mag_s    = b_neg_s ? (ZERO - op_b) : op_b;
    q_fix_s    = (sign_a_q ^ sign_b_q) ? (ZERO - quo_q) : quo_q;
    r_fix_s    = sign_a_q ? (ZERO - rem_q) : rem_q;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= DS_IDLE;
      cnt_q     <= CNT_ZERO;
      rem_q     <= ZERO;
      quo_q     <= ZERO;
      divisor_q <= ZERO;
      result_q  <= ZERO;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      is_rem_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      divisor_q <= divisor_d;
      result_q  <= result_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      is_rem_q  <= is_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = DS_IDLE;
    end else begin
      case (state_q)
        DS_IDLE: begin
          if (accept_s) begin
            state_d = (div_zero_s || overflow_s) ? DS_DONE : DS_CALC;
          end else begin
            state_d = DS_IDLE;
          end
        end
        DS_CALC: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = DS_FIX;
          end else begin
            state_d = DS_CALC;
          end
        end
        DS_FIX:  state_d = DS_DONE;
        DS_DONE: state_d = DS_IDLE;
        default: state_d = DS_IDLE;
      endcase
    end
  end

  // Datapath updates: capture, iterate, sign fix-up and corner results.
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    divisor_d = divisor_q;
    result_d  = result_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    is_rem_d  = is_rem_q;
    if (flush) begin
      result_d = result_q;
    end else begin
      case (state_q)
        DS_IDLE: begin
          if (accept_s) begin
            cnt_d     = CNT_LAST;
            rem_d     = ZERO;
            quo_d     = a_mag_s;
            divisor_d = b_mag_s;
            sign_a_d  = a_neg_s;
            sign_b_d  = b_neg_s;
            is_rem_d  = rem_sel_s;
            if (div_zero_s) begin
              result_d = rem_sel_s ? op_a : ALL_ONES;
            end else if (overflow_s) begin
              result_d = rem_sel_s ? ZERO : MIN_NEG;
            end else begin
              result_d = result_q;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        DS_CALC: begin
          rem_d = step_rem_s;
          quo_d = step_quo_s;
          if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            cnt_d = CNT_ZERO;
          end
        end
        DS_FIX:  result_d = is_rem_q ? r_fix_s : q_fix_s;
        DS_DONE: result_d = result_q;
        default: result_d = result_q;
      endcase
    end
  end

  // Registered status outputs follow the upcoming state.
  always_comb begin
    busy_d = (state_d == DS_CALC) || (state_d == DS_FIX);
    done_d = (state_d == DS_DONE);
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign stall  = busy_q || accept_s;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer; cycle 0 is the accept cycle of each op.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic        clk, rst_n, start, flush;
  logic [4:0]  alu_sel;
  logic [31:0] op_a, op_b;
  logic        busy, stall, done;
  logic [31:0] result;

  int tests_run = 0;
  int tests_failed = 0;

  div_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .alu_sel(alu_sel),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at a negedge: presents the request for cycle 0, returns at the negedge of cycle 1.
  task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                       output logic stall0);
    start = 1'b1; alu_sel = sel; op_a = a; op_b = b;
    #1 stall0 = stall;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles until done is seen; done_cyc = -1 on timeout.
  task automatic wait_done(input int start_cyc, input int limit, output int done_cyc,
                           output int busy_cnt, output logic [31:0] res, output logic stall_d);
    int cyc;
    cyc = start_cyc; busy_cnt = 0; done_cyc = -1; res = 32'd0; stall_d = 1'b1;
    while (1) begin
      if (done === 1'b1) begin
        done_cyc = cyc; res = result; stall_d = stall;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      if (cyc >= limit) break;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; alu_sel = 5'd0; op_a = 32'd0; op_b = 32'd0;
    #2;
    tests_run++;
    if ({busy, done, stall, result} !== 35'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy=%b done=%b stall=%b result=%h, expected all 0", busy, done, stall, result);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_normal(input string name, input logic [4:0] sel, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_res);
    logic s0, sd; int dc, bc; logic [31:0] r;
    issue(sel, a, b, s0);
    wait_done(1, 60, dc, bc, r, sd);
    tests_run++;
    if (s0 !== 1'b1 || dc != 34 || bc != 33 || r !== exp_res || sd !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: stall0=%b done_cyc=%0d busy_cycles=%0d result=%h stall_at_done=%b, expected 1/34/33/%h/0",
               name, s0, dc, bc, r, sd, exp_res);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp_res) begin
      tests_failed++;
      $display("FAIL %s_after: done=%b busy=%b result=%h, expected 0/0/%h", name, done, busy, result, exp_res);
    end
  endtask

  task automatic run_corner(input string name, input logic [4:0] sel, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_res);
    logic s0, sd; int dc, bc; logic [31:0] r;
    issue(sel, a, b, s0);
    wait_done(1, 10, dc, bc, r, sd);
    tests_run++;
    if (s0 !== 1'b1 || dc != 1 || bc != 0 || r !== exp_res) begin
      tests_failed++;
      $display("FAIL %s: stall0=%b done_cyc=%0d busy_cycles=%0d result=%h, expected 1/1/0/%h",
               name, s0, dc, bc, r, exp_res);
    end
    @(negedge clk);
  endtask

  task automatic test_unsigned;
    run_normal("divu_100_7", ALU_DIVU, 32'd100, 32'd7, 32'd14);
    run_normal("remu_100_7", ALU_REMU, 32'd100, 32'd7, 32'd2);
    run_normal("divu_max_1", ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    run_normal("remu_max_maxm1", ALU_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1);
  endtask

  task automatic test_signed;
    run_normal("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_normal("rem_m7_2", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_normal("div_7_m2", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run_normal("rem_7_m2", ALU_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);
  endtask

  task automatic test_corners;
    run_corner("divu_by_zero", ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_corner("rem_by_zero", ALU_REM, 32'd5, 32'd0, 32'd5);
    run_corner("div_overflow", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_corner("rem_overflow", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
  endtask

  task automatic test_invalid_code;
    logic s0;
    issue(5'd0, 32'd100, 32'd7, s0);
    tests_run++;
    if (s0 !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL invalid_code: stall0=%b busy=%b done=%b, expected 0/0/0", s0, busy, done);
    end
  endtask

  task automatic test_start_in_done;
    logic s0, sd, sdone; int dc, bc; logic [31:0] r;
    issue(ALU_DIVU, 32'd9, 32'd0, s0);
    wait_done(1, 10, dc, bc, r, sd);
    start = 1'b1; alu_sel = ALU_DIVU; op_a = 32'd9; op_b = 32'd3;
    #1 sdone = stall;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if (dc != 1 || sdone !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || result !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL start_in_done: done_cyc=%0d stall=%b busy=%b done=%b result=%h, expected 1/0/0/0/ffffffff",
               dc, sdone, busy, done, result);
    end
  endtask

  task automatic test_flush;
    logic s0, sd, saw_done; int dc, bc; logic [31:0] r;
    saw_done = 1'b0;
    issue(ALU_DIVU, 32'd1000, 32'd3, s0);
    for (int c = 1; c < 10; c++) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || saw_done || result !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL flush_abort: busy=%b done=%b saw_done=%b result=%h, expected 0/0/0/ffffffff",
               busy, done, saw_done, result);
    end
    issue(ALU_DIVU, 32'd9, 32'd3, s0);
    wait_done(12, 80, dc, bc, r, sd);
    tests_run++;
    if (dc != 45 || r !== 32'd3) begin
      tests_failed++;
      $display("FAIL flush_restart: done_cyc=%0d result=%h, expected 45/00000003", dc, r);
    end
    @(negedge clk);
  endtask

  task automatic test_flush_vs_start;
    logic s0;
    flush = 1'b1;
    issue(ALU_DIVU, 32'd50, 32'd5, s0);
    flush = 1'b0;
    tests_run++;
    if (s0 !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_priority: stall0=%b busy=%b done=%b, expected 0/0/0", s0, busy, done);
    end
  endtask

  task automatic test_start_while_busy;
    logic s0, sd; int dc, bc; logic [31:0] r;
    issue(ALU_DIVU, 32'd100, 32'd7, s0);
    repeat (4) @(negedge clk);
    start = 1'b1; alu_sel = ALU_DIVU; op_a = 32'd200; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, 60, dc, bc, r, sd);
    tests_run++;
    if (dc != 34 || r !== 32'd14) begin
      tests_failed++;
      $display("FAIL start_while_busy: done_cyc=%0d result=%h, expected 34/0000000e", dc, r);
    end
  endtask

  task automatic test_back_to_back;
    logic s0, sd; int dc, bc; logic [31:0] r;
    @(negedge clk);
    issue(ALU_REMU, 32'd100, 32'd7, s0);
    wait_done(1, 60, dc, bc, r, sd);
    tests_run++;
    if (s0 !== 1'b1 || dc != 34 || r !== 32'd2) begin
      tests_failed++;
      $display("FAIL back_to_back: stall0=%b done_cyc=%0d result=%h, expected 1/34/00000002", s0, dc, r);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    logic s0;
    issue(ALU_DIVU, 32'd1000, 32'd3, s0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      tests_failed++;
      $display("FAIL async_reset: busy=%b done=%b result=%h, expected 0/0/00000000", busy, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: busy=%b done=%b result=%h, expected 0/0/00000000", busy, done, result);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_corners();
    test_invalid_code();
    test_start_in_done();
    test_flush();
    test_flush_vs_start();
    test_start_while_busy();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle sequencer for the M-extension divide/remainder operations (DIV, DIVU, REM, REMU), which the single-cycle ALU cannot complete. It accepts an operation from the execute stage and stalls the pipeline while it runs a 32-step restoring division on operand magnitudes. It then applies RISC-V sign and corner-case rules and returns the result with a one-cycle done pulse. MUL* operations stay in the ALU and never reach this block.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- alu_sel  input  5  operation code (`ALU_DIV, `ALU_DIVU, `ALU_REM, `ALU_REMU); other codes at start are ignored (no accept)
- op_a  input  WIDTH  dividend, captured on accept
- op_b  input  WIDTH  divisor, captured on accept
- flush  input  1  abort current operation (pipeline flush)
- busy  output  1  registered; high in CALC and FIX
- stall  output  1  combinational; busy OR (accepted start this cycle)
- done  output  1  registered one-cycle pulse; result valid
- result  output  WIDTH  registered; holds last result until next done

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: on start with a valid div code, capture the operands, the signed/unsigned flag and the quotient/remainder flag.
  - Zero divisor or signed overflow (op_a = 0x8000_0000, op_b = all ones, DIV/REM): go straight to DONE.
  - Otherwise go to CALC. Signed ops latch |op_a| and |op_b|, plus sign bits; counter := WIDTH-1.
- CALC: one restoring step per cycle.
  - {rem,quo} shifts left one bit.
  - trial = rem − divisor; if trial is non-negative, rem := trial and quo LSB := 1.
  - Counter decrements; after the step with counter = 0, go to FIX.
- FIX (signed ops): quotient negated if sign_a XOR sign_b; remainder negated if sign_a. Load result and go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE. A start is not accepted in DONE.
- Corner-case results:
  - divide by zero: quotient = all ones; remainder = op_a (unsigned and signed).
  - signed overflow: quotient = 0x8000_0000; remainder = 0.
- flush: from any state, next state is IDLE; done is not asserted and result is unchanged. flush has priority over start in the same cycle.
- start while busy or in DONE: ignored; the operands are not re-captured.
- Reset values: state IDLE; busy 0, done 0, result 0; counter 0; internal registers 0.

## Timing
- Accept at cycle 0 (start high in IDLE). stall is high from cycle 0 combinationally.
- Normal path: CALC for cycles 1..WIDTH, FIX at WIDTH+1, done at WIDTH+2 (34 for WIDTH = 32).
- Corner path: done at cycle 1.
- stall is low in the done cycle, so the pipeline advances and consumes result that cycle.
- busy falls in the done cycle.
- Reset mid-operation: outputs go to their reset values immediately (asynchronous); no done pulse.
- Back-to-back operations: the earliest next accept is the cycle after done.

## Structure
- The `ALU_DIV/DIVU/REM/REMU codes are already in defines.v and are reused.
- Add the state encodings (DS_IDLE, DS_CALC, DS_FIX, DS_DONE) to defines.v.
- Sub-module `div_iter_step`: combinational shift-subtract-restore step, WIDTH-parameterized.
  - Inputs: rem, quo, divisor. Outputs: next rem, next quo.
- The sequencer holds the FSM, the counter, the sign handling and the result register.

## Test plan
- DIVU 100 / 7 -> result 14 at cycle 34; REMU with the same operands -> result 2; busy high in cycles 1–33; done high only in cycle 34.
- DIV 0xFFFF_FFF9 (−7) / 2 -> 0xFFFF_FFFD (−3); REM with the same operands -> 0xFFFF_FFFF (−1).
- DIVU 5 / 0 -> 0xFFFF_FFFF and REM 5 / 0 -> 5, each at cycle 1 with no CALC cycles.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM with the same operands -> 0; each at cycle 1.
- Start DIVU 1000 / 3, then flush at cycle 10:
  - busy low at cycle 11, no done, result unchanged.
  - A new start at cycle 11 completes at cycle 45 with the correct value (DIVU 9 / 3 -> 3).
- Second start with different operands at cycle 5 of a running op -> ignored; the first op's result is unchanged at cycle 34.
- rst_n low at cycle 20 -> busy, done and result are 0 asynchronously.
